// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry, requester IDs and the arbiter state encoding.
package cpu_pkg;

  localparam int MEM_AW = 7;
  localparam int MEM_DW = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory macro signals around mem_arbiter.
interface mem_arbiter_if #(
  parameter int AW = cpu_pkg::MEM_AW,
  parameter int DW = cpu_pkg::MEM_DW
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // The arbiter's view: requests and read data in, grants, responses and strobes out.
  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    winner = REQ_I;
    gnt    = 2'b00;
    if (i_req && d_req) begin
      winner = (last_gnt == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      winner = REQ_D;
    end
    if (i_req || d_req) begin
      gnt = (winner == REQ_D) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch (I) and load/store (D) ports,
// one fixed-latency transaction at a time.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t state;
  arb_state_t state_next;

  logic       last_gnt;
  logic       owner;
  logic       is_store;
  logic [1:0] wait_cnt;

  logic [1:0] pick;
  logic       winner;
  logic       can_grant;
  logic       grant;
  logic       wait_done;

  rr_pick2 u_pick (
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .last_gnt (last_gnt),
    .gnt      (pick),
    .winner   (winner)
  );

  // Grants are only offered when no transaction is in flight (IDLE or RESP) and never under reset.
  always_comb begin
    state_next = state;
    can_grant  = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        can_grant  = !rst;
        state_next = (bus.i_req || bus.d_req) ? ISSUE : IDLE;
      end
      ISSUE: state_next = WAIT;
      WAIT:  state_next = (wait_cnt == 2'd0) ? RESP : WAIT;
      default: state_next = IDLE;
    endcase
  end

  assign grant     = can_grant && (pick != 2'b00);
  assign wait_done = (state == WAIT) && (wait_cnt == 2'd0);
  assign bus.i_gnt = can_grant && pick[0];
  assign bus.d_gnt = can_grant && pick[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The mem_* registers load straight from the granted request, so the strobe lands in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt      <= REQ_I;
      owner         <= REQ_I;
      is_store      <= 1'b0;
      wait_cnt      <= 2'd0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rvalid  <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rvalid  <= 1'b0;
      bus.d_rvalid  <= 1'b0;

      if (grant) begin
        last_gnt   <= winner;
        owner      <= winner;
        bus.mem_en <= 1'b1;
        if (winner == REQ_D) begin
          is_store      <= bus.d_we;
          bus.mem_we    <= bus.d_we;
          bus.mem_be    <= bus.d_we ? bus.d_be : 4'hF;
          bus.mem_addr  <= bus.d_addr;
          bus.mem_wdata <= bus.d_we ? bus.d_wdata : '0;
        end else begin
          is_store     <= 1'b0;
          bus.mem_be   <= 4'hF;
          bus.mem_addr <= bus.i_addr;
        end
      end

      if (state == ISSUE) begin
        wait_cnt <= 2'(LAT - 1);
      end else if (state == WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end

      // Each port's rdata register only changes when that port owns the completing access.
      if (wait_done) begin
        if (owner == REQ_D) begin
          bus.d_rvalid <= 1'b1;
          bus.d_rdata  <= is_store ? '0 : bus.mem_rdata;
        end else begin
          bus.i_rvalid <= 1'b1;
          bus.i_rdata  <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table on a LAT=1 instance
// plus a hand-written latency sequence on a LAT=4 instance.
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam logic [31:0] W5  = 32'h0050_0093;
  localparam logic [31:0] M1  = 32'h1000_0001;
  localparam logic [31:0] M2  = 32'h1000_0002;
  localparam logic [31:0] M3  = 32'h1000_0003;
  localparam logic [31:0] M6  = 32'h1000_0006;
  localparam logic [31:0] M7  = 32'h1000_0007;
  localparam logic [31:0] M8  = 32'h1000_0008;
  localparam logic [31:0] RB  = 32'h1122_BEEF;
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(7), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(7), .DW(32)) bus4 ();

  mem_arbiter #(.LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_arbiter #(.LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Memory models: image reloads on reset; read data exists only LAT cycles after the strobe.
  logic [31:0] mem1 [128];
  logic [31:0] mem4 [128];
  logic [31:0] pipe1;
  logic [31:0] pipe4 [4];

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 128; a++) mem1[a] <= 32'h1000_0000 + 32'(a);
      mem1[5] <= W5;
      mem1[9] <= 32'h1122_3344;
    end else if (bus1.mem_en && bus1.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus1.mem_be[b]) mem1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
    end
    pipe1 <= bus1.mem_en ? mem1[bus1.mem_addr] : BAD;
  end
  assign bus1.mem_rdata = pipe1;

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 128; a++) mem4[a] <= 32'h1000_0000 + 32'(a);
      mem4[5] <= W5;
    end else if (bus4.mem_en && bus4.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus4.mem_be[b]) mem4[bus4.mem_addr][8*b +: 8] <= bus4.mem_wdata[8*b +: 8];
    end
    pipe4[0] <= bus4.mem_en ? mem4[bus4.mem_addr] : BAD;
    for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
  end
  assign bus4.mem_rdata = pipe4[3];

  typedef struct packed {
    logic        rst;
    logic        i_req;
    logic [6:0]  i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [6:0]  d_addr;
    logic [31:0] d_wdata;
  } stim_t;

  typedef struct packed {
    logic        i_gnt;
    logic        d_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        i_rvalid;
    logic        d_rvalid;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } obs_t;

  typedef struct {
    string name;
    stim_t stim;
    obs_t  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic stim_t st(logic r, logic ir, logic [6:0] ia, logic dr, logic dw,
                               logic [3:0] be, logic [6:0] da, logic [31:0] wd);
    stim_t s;
    s.rst = r; s.i_req = ir; s.i_addr = ia; s.d_req = dr;
    s.d_we = dw; s.d_be = be; s.d_addr = da; s.d_wdata = wd;
    return s;
  endfunction

  function automatic obs_t ob(logic ig, logic dg, logic en, logic we, logic [3:0] be,
                              logic [6:0] ad, logic [31:0] wd, logic irv, logic drv,
                              logic [31:0] ird, logic [31:0] drd);
    obs_t o;
    o.i_gnt = ig; o.d_gnt = dg; o.mem_en = en; o.mem_we = we; o.mem_be = be;
    o.mem_addr = ad; o.mem_wdata = wd; o.i_rvalid = irv; o.d_rvalid = drv;
    o.i_rdata = ird; o.d_rdata = drd;
    return o;
  endfunction

  task automatic addVec(string name, stim_t s, obs_t e);
    vec_t v;
    v.name = name; v.stim = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(stim_t s);
    rst          = s.rst;
    bus1.i_req   = s.i_req;
    bus1.i_addr  = s.i_addr;
    bus1.d_req   = s.d_req;
    bus1.d_we    = s.d_we;
    bus1.d_be    = s.d_be;
    bus1.d_addr  = s.d_addr;
    bus1.d_wdata = s.d_wdata;
  endtask

  task automatic checkOutput(string name, obs_t exp);
    obs_t act;
    act = ob(bus1.i_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.mem_be, bus1.mem_addr,
             bus1.mem_wdata, bus1.i_rvalid, bus1.d_rvalid, bus1.i_rdata, bus1.d_rdata);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  stim_t idl;
  int    t0;
  logic  got;
  logic  busy_gnt;

  initial begin
    idl = st(0, 0, 0, 0, 0, 4'hF, 0, 0);
    // ob fields: i_gnt d_gnt en we be addr wdata i_rv d_rv i_rdata d_rdata
    addVec("rst_gnt_low",  st(1, 1, 5, 1, 0, 4'hF, 7, 0),  ob(0,0,0,0,4'h0,0,0,0,0,0,0));
    addVec("i_gnt",        st(0, 1, 5, 0, 0, 4'hF, 0, 0),  ob(1,0,0,0,4'h0,0,0,0,0,0,0));
    addVec("i_issue",      idl,                            ob(0,0,1,0,4'hF,5,0,0,0,0,0));
    addVec("i_wait",       idl,                            ob(0,0,0,0,4'h0,0,0,0,0,0,0));
    addVec("i_resp",       idl,                            ob(0,0,0,0,4'h0,0,0,1,0,W5,0));
    addVec("i_hold",       idl,                            ob(0,0,0,0,4'h0,0,0,0,0,W5,0));
    addVec("tie_d",        st(0, 1, 3, 1, 0, 4'hF, 7, 0),  ob(0,1,0,0,4'h0,0,0,0,0,W5,0));
    addVec("tie_d_issue",  st(0, 1, 3, 0, 0, 4'hF, 7, 0),  ob(0,0,1,0,4'hF,7,0,0,0,W5,0));
    addVec("tie_wait",     st(0, 1, 3, 0, 0, 4'hF, 7, 0),  ob(0,0,0,0,4'h0,0,0,0,0,W5,0));
    addVec("tie_d_resp",   st(0, 1, 3, 0, 0, 4'hF, 7, 0),  ob(1,0,0,0,4'h0,0,0,0,1,W5,M7));
    addVec("tie_i_issue",  idl,                            ob(0,0,1,0,4'hF,3,0,0,0,W5,M7));
    addVec("tie_i_wait",   idl,                            ob(0,0,0,0,4'h0,0,0,0,0,W5,M7));
    addVec("tie_i_resp",   idl,                            ob(0,0,0,0,4'h0,0,0,1,0,M3,M7));
    addVec("st_gnt",       st(0, 0, 0, 1, 1, 4'h3, 9, 32'hDEADBEEF), ob(0,1,0,0,4'h0,0,0,0,0,M3,M7));
    addVec("st_issue",     st(0, 0, 0, 0, 1, 4'hF, 9, 0),  ob(0,0,1,1,4'h3,9,32'hDEADBEEF,0,0,M3,M7));
    addVec("st_wait",      idl,                            ob(0,0,0,0,4'h0,0,0,0,0,M3,M7));
    addVec("st_ack_b2b",   st(0, 0, 0, 1, 0, 4'hF, 9, 0),  ob(0,1,0,0,4'h0,0,0,0,1,M3,0));
    addVec("rd9_issue",    idl,                            ob(0,0,1,0,4'hF,9,0,0,0,M3,0));
    addVec("rd9_wait",     idl,                            ob(0,0,0,0,4'h0,0,0,0,0,M3,0));
    addVec("rd9_half",     idl,                            ob(0,0,0,0,4'h0,0,0,0,1,M3,RB));
    addVec("be0_gnt",      st(0, 0, 0, 1, 1, 4'h0, 9, 32'hFFFFFFFF), ob(0,1,0,0,4'h0,0,0,0,0,M3,RB));
    addVec("be0_issue",    idl,                            ob(0,0,1,1,4'h0,9,32'hFFFFFFFF,0,0,M3,RB));
    addVec("be0_wait",     idl,                            ob(0,0,0,0,4'h0,0,0,0,0,M3,RB));
    addVec("be0_ack",      idl,                            ob(0,0,0,0,4'h0,0,0,0,1,M3,0));
    addVec("wd_dgnt",      st(0, 0, 0, 1, 0, 4'hF, 2, 0),  ob(0,1,0,0,4'h0,0,0,0,0,M3,0));
    addVec("wd_ireq_iss",  st(0, 1, 4, 0, 0, 4'hF, 0, 0),  ob(0,0,1,0,4'hF,2,0,0,0,M3,0));
    addVec("wd_ireq_wait", st(0, 1, 4, 0, 0, 4'hF, 0, 0),  ob(0,0,0,0,4'h0,0,0,0,0,M3,0));
    addVec("wd_drop_resp", idl,                            ob(0,0,0,0,4'h0,0,0,0,1,M3,M2));
    addVec("wd_no_en_a",   idl,                            ob(0,0,0,0,4'h0,0,0,0,0,M3,M2));
    addVec("wd_no_en_b",   idl,                            ob(0,0,0,0,4'h0,0,0,0,0,M3,M2));
    addVec("rr_tie_i",     st(0, 1, 1, 1, 0, 4'hF, 6, 0),  ob(1,0,0,0,4'h0,0,0,0,0,M3,M2));
    addVec("rr_issue",     st(0, 0, 1, 1, 0, 4'hF, 6, 0),  ob(0,0,1,0,4'hF,1,0,0,0,M3,M2));
    addVec("rst_in_wait",  st(1, 1, 1, 1, 0, 4'hF, 6, 0),  ob(0,0,0,0,4'h0,0,0,0,0,M3,M2));
    addVec("post_rst_d",   st(0, 1, 1, 1, 0, 4'hF, 6, 0),  ob(0,1,0,0,4'h0,0,0,0,0,0,0));
    addVec("post_issue",   idl,                            ob(0,0,1,0,4'hF,6,0,0,0,0,0));
    addVec("post_wait",    idl,                            ob(0,0,0,0,4'h0,0,0,0,0,0,0));
    addVec("post_resp",    idl,                            ob(0,0,0,0,4'h0,0,0,0,1,0,M6));
    addVec("post_hold",    idl,                            ob(0,0,0,0,4'h0,0,0,0,0,0,M6));

    bus4.i_req = 0; bus4.i_addr = 0; bus4.d_req = 0; bus4.d_we = 0;
    bus4.d_be = 4'hF; bus4.d_addr = 0; bus4.d_wdata = 0;
    applyStimulus(st(1, 0, 0, 0, 0, 4'hF, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].stim);
      @(negedge clk);
      checkOutput(vecs[n].name, vecs[n].exp);
      @(posedge clk);
      #1;
    end
    applyStimulus(idl);

    // LAT=4: fetch followed by a load that waits out the whole busy window.
    bus4.i_req = 1; bus4.i_addr = 5;
    @(negedge clk);
    checkVal("lat4_i_gnt", 32'(bus4.i_gnt), 1);
    t0 = cyc;
    @(posedge clk);
    #1;
    bus4.i_req = 0; bus4.d_req = 1; bus4.d_we = 0; bus4.d_addr = 8;
    got = 0; busy_gnt = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus4.i_rvalid) got = 1;
      else if (bus4.i_gnt || bus4.d_gnt) busy_gnt = 1;
    end
    checkVal("lat4_i_rvalid_seen", 32'(got), 1);
    checkVal("lat4_i_gnt_to_rvalid", 32'(cyc - t0), 6);
    checkVal("lat4_i_rdata", bus4.i_rdata, W5);
    checkVal("lat4_no_gnt_busy", 32'(busy_gnt), 0);
    checkVal("lat4_d_gnt_in_resp", 32'(bus4.d_gnt), 1);
    t0 = cyc;
    @(posedge clk);
    #1;
    bus4.d_req = 0;
    got = 0; busy_gnt = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus4.d_rvalid) got = 1;
      else if (bus4.i_rvalid) busy_gnt = 1;
    end
    checkVal("lat4_d_rvalid_seen", 32'(got), 1);
    checkVal("lat4_d_gnt_to_rvalid", 32'(cyc - t0), 6);
    checkVal("lat4_d_rdata", bus4.d_rdata, M8);
    checkVal("lat4_no_stray_i_rvalid", 32'(busy_gnt), 0);
    checkVal("lat4_i_rdata_held", bus4.i_rdata, W5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
